// File: rtl/sobel_conv.sv
// Sobel edge stage: RGB444 3x3 window -> grayscale -> Gx/Gy -> passthrough / magnitude / threshold, border windows forced to black.
// Latency 3 cycles (input edge N -> output edge N+3); no backpressure, one window per cycle, gaps pass straight through.
module sobel_conv #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int MAG_SHIFT  = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [2:0][2:0][11:0]  data_matrix,
    input  logic                   pixel_valid,
    input  logic                   sof,
    input  logic [1:0]             mode,
    input  logic [8:0]             threshold,
    output logic [11:0]            pixel_out,
    output logic                   pixel_valid_out
);

    localparam int COL_W = (IMG_WIDTH  > 2) ? $clog2(IMG_WIDTH)  : 2;
    localparam int ROW_W = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT) : 2;

    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic [COL_W-1:0] w_col_eff;
    logic [ROW_W-1:0] w_row_eff;
    logic             w_col_wrap;
    logic             w_row_wrap;
    logic             w_mask;

    // sof zeroes the position seen by a window arriving in the same cycle
    always_comb begin
        w_col_eff  = sof ? '0 : r_col;
        w_row_eff  = sof ? '0 : r_row;
        w_col_wrap = (w_col_eff == COL_W'(IMG_WIDTH - 1));
        w_row_wrap = (w_row_eff == ROW_W'(IMG_HEIGHT - 1));
        w_mask     = (w_col_eff < COL_W'(2)) || (w_row_eff < ROW_W'(2));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (pixel_valid) begin
            if (w_col_wrap) begin
                r_col <= '0;
                r_row <= w_row_wrap ? '0 : w_row_eff + ROW_W'(1);
            end else begin
                r_col <= w_col_eff + COL_W'(1);
                r_row <= w_row_eff;
            end
        end else if (sof) begin
            r_col <= '0;
            r_row <= '0;
        end
    end

    logic [2:0][2:0][5:0] w_gray;

    always_comb begin
        w_gray = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                w_gray[r][c] = 6'(data_matrix[r][c][11:8])
                             + 6'(data_matrix[r][c][7:4])
                             + 6'(data_matrix[r][c][3:0]);
            end
        end
    end

    logic [2:0][2:0][5:0] r1_g;
    logic [11:0]          r1_ctr;
    logic [1:0]           r1_mode;
    logic [8:0]           r1_thr;
    logic                 r1_mask;
    logic                 r1_vld;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r1_g    <= '0;
            r1_ctr  <= '0;
            r1_mode <= '0;
            r1_thr  <= '0;
            r1_mask <= 1'b0;
            r1_vld  <= 1'b0;
        end else begin
            r1_g    <= w_gray;
            r1_ctr  <= data_matrix[1][1];
            r1_mode <= mode;
            r1_thr  <= threshold;
            r1_mask <= w_mask;
            r1_vld  <= pixel_valid;
        end
    end

    // Each side of a kernel sums to at most 4*45 = 180, so 9-bit two's complement holds the difference
    logic [8:0] w_gx_pos;
    logic [8:0] w_gx_neg;
    logic [8:0] w_gy_pos;
    logic [8:0] w_gy_neg;
    logic [8:0] w_gx;
    logic [8:0] w_gy;

    always_comb begin
        w_gx_pos = 9'(r1_g[0][0]) + 9'({r1_g[1][0], 1'b0}) + 9'(r1_g[2][0]);
        w_gx_neg = 9'(r1_g[0][2]) + 9'({r1_g[1][2], 1'b0}) + 9'(r1_g[2][2]);
        w_gy_pos = 9'(r1_g[0][0]) + 9'({r1_g[0][1], 1'b0}) + 9'(r1_g[0][2]);
        w_gy_neg = 9'(r1_g[2][0]) + 9'({r1_g[2][1], 1'b0}) + 9'(r1_g[2][2]);
        w_gx     = w_gx_pos - w_gx_neg;
        w_gy     = w_gy_pos - w_gy_neg;
    end

    logic [8:0]  r2_gx;
    logic [8:0]  r2_gy;
    logic [11:0] r2_ctr;
    logic [1:0]  r2_mode;
    logic [8:0]  r2_thr;
    logic        r2_mask;
    logic        r2_vld;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r2_gx   <= '0;
            r2_gy   <= '0;
            r2_ctr  <= '0;
            r2_mode <= '0;
            r2_thr  <= '0;
            r2_mask <= 1'b0;
            r2_vld  <= 1'b0;
        end else begin
            r2_gx   <= w_gx;
            r2_gy   <= w_gy;
            r2_ctr  <= r1_ctr;
            r2_mode <= r1_mode;
            r2_thr  <= r1_thr;
            r2_mask <= r1_mask;
            r2_vld  <= r1_vld;
        end
    end

    logic [8:0]  w_abs_x;
    logic [8:0]  w_abs_y;
    logic [8:0]  w_mag;
    logic [8:0]  w_mag_sh;
    logic [3:0]  w_m4;
    logic [11:0] w_result;

    always_comb begin
        w_abs_x  = r2_gx[8] ? (~r2_gx + 9'd1) : r2_gx;
        w_abs_y  = r2_gy[8] ? (~r2_gy + 9'd1) : r2_gy;
        w_mag    = w_abs_x + w_abs_y;
        w_mag_sh = w_mag >> MAG_SHIFT;
        w_m4     = (w_mag_sh > 9'd15) ? 4'hF : w_mag_sh[3:0];
        w_result = '0;
        if (!r2_mask) begin
            case (r2_mode)
                2'b00:   w_result = r2_ctr;
                2'b10:   w_result = (w_mag >= r2_thr) ? 12'hFFF : 12'h000;
                default: w_result = {w_m4, w_m4, w_m4};
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pixel_out       <= '0;
            pixel_valid_out <= 1'b0;
        end else begin
            pixel_valid_out <= r2_vld;
            if (r2_vld) begin
                pixel_out <= w_result;
            end
        end
    end

endmodule

// File: tb/tb_sobel_conv.sv
// Scoreboard bench for sobel_conv: directed windows push expected pixel + arrival cycle; a negedge monitor checks outputs.
module tb_sobel_conv;

    typedef logic [2:0][2:0][11:0] win_t;
    typedef struct {
        int          cyc;
        logic [11:0] pix;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    win_t        data_matrix = '0;
    logic        pixel_valid = 1'b0;
    logic        sof = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [8:0]  threshold = 9'd0;
    logic [11:0] pixel_out;
    logic        pixel_valid_out;

    exp_t        exp_q[$];
    int          cyc = 0;
    logic        rst_q = 1'b0;
    logic        done = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [11:0] last_exp = 12'h000;
    int          bcol = 0;

    sobel_conv dut (
        .clk             (clk),
        .rst             (rst),
        .data_matrix     (data_matrix),
        .pixel_valid     (pixel_valid),
        .sof             (sof),
        .mode            (mode),
        .threshold       (threshold),
        .pixel_out       (pixel_out),
        .pixel_valid_out (pixel_valid_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    function automatic win_t uni(input logic [11:0] p);
        win_t w;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                w[r][c] = p;
        return w;
    endfunction

    function automatic win_t col2(input logic [11:0] p);
        win_t w;
        w = '0;
        for (int r = 0; r < 3; r++) w[r][2] = p;
        return w;
    endfunction

    function automatic win_t rowv(input int rr, input logic [11:0] p);
        win_t w;
        w = '0;
        for (int c = 0; c < 3; c++) w[rr][c] = p;
        return w;
    endfunction

    function automatic win_t ctr(input logic [11:0] p);
        win_t w;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                w[r][c] = 12'($urandom());
        w[1][1] = p;
        return w;
    endfunction

    // Drive one cycle of inputs; a valid window with reset released expects its pixel 3 edges later
    task automatic apply(input win_t w, input logic v, input logic s, input logic [1:0] m,
                         input logic [8:0] t, input logic [11:0] e, input logic r = 1'b1);
        data_matrix = w;
        pixel_valid = v;
        sof         = s;
        mode        = m;
        threshold   = t;
        rst         = r;
        if (v && r) exp_q.push_back('{cyc + 3, e});
        if (!r)          bcol = 0;
        else if (s)      bcol = v ? 1 : 0;
        else if (v)      bcol = (bcol == 639) ? 0 : bcol + 1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic r = 1'b1);
        for (int i = 0; i < n; i++) apply(uni(12'h000), 1'b0, 1'b0, 2'b00, 9'd0, 12'h000, r);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst_q) begin
            exp_q.delete();
            last_exp = 12'h000;
            n_cmp++;
            if (pixel_out !== 12'h000 || pixel_valid_out !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_state: pixel_out=%h valid=%b, required 000/0", pixel_out, pixel_valid_out);
            end
        end else if (pixel_valid_out) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_valid: pixel_out=%h at cycle %0d, required no output", pixel_out, cyc);
            end else begin
                e = exp_q.pop_front();
                if (pixel_out !== e.pix || cyc != e.cyc) begin
                    n_bad++;
                    $display("FAIL pixel: got %h at cycle %0d, required %h at cycle %0d", pixel_out, cyc, e.pix, e.cyc);
                end
                last_exp = e.pix;
            end
        end else begin
            n_cmp++;
            if (pixel_out !== last_exp) begin
                n_bad++;
                $display("FAIL hold: pixel_out=%h while idle, required %h", pixel_out, last_exp);
            end
            if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                n_cmp++;
                n_bad++;
                $display("FAIL missing_valid: valid=0 at cycle %0d, required pixel %h at cycle %0d", cyc, e.pix, e.cyc);
            end
        end
        if (done || cyc > 20000) begin
            if (!done) begin
                n_cmp++;
                n_bad++;
                $display("FAIL timeout: cycle %0d, required stimulus to complete", cyc);
            end
            if (exp_q.size() != 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL leftover: %0d expected outputs never seen, required 0", exp_q.size());
            end
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
            $finish;
        end
    end

    initial begin
        #1;
        idle(3, 1'b0);
        idle(10);

        // Two full lines of flat grey plus two columns reach the first unmasked window (col 2, row 2)
        apply(uni(12'h888), 1'b1, 1'b1, 2'b01, 9'd0, 12'h000);
        for (int i = 0; i < 1281; i++) apply(uni(12'h888), 1'b1, 1'b0, 2'b01, 9'd0, 12'h000);

        apply(col2(12'hFFF),    1'b1, 1'b0, 2'b01, 9'd0,   12'hFFF);
        apply(col2(12'hFFF),    1'b1, 1'b0, 2'b10, 9'd200, 12'h000);
        apply(col2(12'hFFF),    1'b1, 1'b0, 2'b10, 9'd180, 12'hFFF);
        apply(col2(12'hFFF),    1'b1, 1'b0, 2'b10, 9'd181, 12'h000);
        apply(col2(12'h111),    1'b1, 1'b0, 2'b01, 9'd0,   12'h111);
        apply(col2(12'h111),    1'b1, 1'b0, 2'b11, 9'd0,   12'h111);
        apply(rowv(0, 12'h333), 1'b1, 1'b0, 2'b01, 9'd0,   12'h444);
        apply(rowv(2, 12'h333), 1'b1, 1'b0, 2'b01, 9'd0,   12'h444);
        apply(ctr(12'hABC),     1'b1, 1'b0, 2'b00, 9'd0,   12'hABC);
        apply(ctr(12'h123),     1'b1, 1'b0, 2'b00, 9'd0,   12'h123);
        apply(ctr(12'hFFF),     1'b0, 1'b0, 2'b00, 9'd0,   12'h000);
        apply(ctr(12'h456),     1'b1, 1'b0, 2'b00, 9'd0,   12'h456);
        apply(ctr(12'h789),     1'b1, 1'b0, 2'b00, 9'd0,   12'h789);

        while (bcol != 0) apply(uni(12'h888), 1'b1, 1'b0, 2'b01, 9'd0, 12'h000);
        apply(ctr(12'hABC), 1'b1, 1'b0, 2'b00, 9'd0, 12'h000);
        apply(ctr(12'hABC), 1'b1, 1'b0, 2'b00, 9'd0, 12'h000);
        apply(ctr(12'hABC), 1'b1, 1'b0, 2'b00, 9'd0, 12'hABC);
        idle(4);

        // Reset lands while two accepted windows and a third presented one are in the pipe
        apply(ctr(12'hDEF), 1'b1, 1'b0, 2'b00, 9'd0, 12'hDEF);
        apply(ctr(12'hDEF), 1'b1, 1'b0, 2'b00, 9'd0, 12'hDEF);
        apply(ctr(12'hDEF), 1'b1, 1'b0, 2'b00, 9'd0, 12'hDEF, 1'b0);
        idle(3);
        apply(ctr(12'hABC), 1'b1, 1'b0, 2'b00, 9'd0, 12'h000);
        idle(6);

        for (int i = 0; i < 30 && exp_q.size() != 0; i++) idle(1);
        done = 1'b1;
    end

endmodule

// File: doc/sobel_conv.md
Name: sobel_conv

Overview:
- Convolution stage directly downstream of the 3x3 line/window buffer.
- Each valid cycle it consumes one 3x3 window of 12-bit RGB444 pixels and converts the window to grayscale.
- It applies horizontal and vertical Sobel kernels and emits one 12-bit output pixel per window through a fixed 3-stage pipeline.
- Output selects passthrough, scaled gradient magnitude, or binary threshold; border windows are masked to black.

Parameters:
IMG_WIDTH, 640, valid windows per line; column counter wraps at this value.
IMG_HEIGHT, 480, lines per frame; row counter wraps at this value.
MAG_SHIFT, 3, right shift applied to gradient magnitude before 4-bit saturation.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous active-low reset; sampled on rising edge of clk.
data_matrix  input  12 x [2:0][2:0]  window; [r][c], r=0 newest line, c=0 newest column; pixel = {R[11:8],G[7:4],B[3:0]}.
pixel_valid  input  1  data_matrix holds a new window this cycle.
sof  input  1  start-of-frame pulse; clears counters.
mode  input  2  00 passthrough, 01 magnitude, 10 threshold, 11 = 01.
threshold  input  9  compare level for mode 10.
pixel_out  output  12  result pixel.
pixel_valid_out  output  1  pixel_out valid this cycle.

Behaviour:
- Reset (rst low at a clock edge):
  - pixel_out, pixel_valid_out, all pipeline registers and both counters go to 0 on that edge.
  - In-flight data is discarded; the first output after release needs a fresh valid input.
- No backpressure. One window is accepted per cycle while pixel_valid=1. The pipeline advances every cycle, and valid bits shift with the data.
- Latency: input valid on edge N -> pixel_valid_out=1 on edge N+3. Input gaps propagate as output gaps.
- Counters:
  - col_cnt advances on each accepted window and wraps IMG_WIDTH-1 -> 0.
  - row_cnt increments when col_cnt wraps and wraps IMG_HEIGHT-1 -> 0.
  - sof=1 forces both counters to 0 before counting. If sof and pixel_valid coincide, that window is col 0/row 0, and the counters become col 1/row 0.
- Border mask: a window is masked when col_cnt<2 or row_cnt<2 at acceptance. Masked windows still produce pixel_valid_out=1, with pixel_out=0x000 in every mode.
- Stage 1 (S1) registers:
  - Nine gray values g[r][c]=R+G+B, each 6-bit unsigned (0..45).
  - The centre pixel data_matrix[1][1].
  - mode, threshold, the mask bit and the valid bit.
- Stage 2 (S2) registers, signed 9-bit, range -180..180:
  - Gx = (g00+2g10+g20) - (g02+2g12+g22).
  - Gy = (g00+2g01+g02) - (g20+2g21+g22).
  - Mode, threshold, mask, centre pixel and valid move along with Gx/Gy.
- Stage 3 (S3), computed into the output registers:
  - mag = |Gx|+|Gy|, 9-bit unsigned, max 360, no overflow.
  - m4 = min(mag>>MAG_SHIFT, 15).
  - Mode 00: pixel_out = centre pixel.
  - Mode 01/11: pixel_out = {m4,m4,m4}.
  - Mode 10: pixel_out = 0xFFF if mag>=threshold, else 0x000.
  - The mask overrides all modes.
- mode and threshold are sampled at S1 per window. A change mid-stream affects only windows accepted after the change.
- When pixel_valid_out=0, pixel_out holds its last value.

Test Plan:
- Reset, then release with pixel_valid=0 -> pixel_out=0x000 and pixel_valid_out=0 for 10 cycles.
- sof, then IMG_WIDTH uniform 0x888 windows in mode 01 -> outputs 0x000 throughout. Valid pulses appear exactly 3 cycles after each input, and the first two are masked.
- With counters past the border (col>=2, row>=2), column c=2 = 0xFFF and c=0,1 = 0x000:
  - Mode 01 -> Gx=-180, Gy=0, mag=180, m4=15, pixel_out=0xFFF.
  - Mode 10 with threshold=200 -> 0x000.
  - Mode 10 with threshold=180 -> 0xFFF.
- Mode 00 with centre pixel 0xABC, other pixels random, counters past the border -> pixel_out=0xABC at N+3. The same window accepted at col_cnt=1 -> 0x000.
- Gapped input (valid 1,0,1,1) -> pixel_valid_out 1,0,1,1 delayed by 3 cycles. sof coinciding with valid -> that window is masked and the next window's col_cnt reads 1.
- Assert rst for one cycle while 3 windows are in flight -> no output valid is produced for those windows. The next valid input appears 3 cycles after it is applied.
